instr_mem_responder: RTL
========================

// Module: instr_mem_responder
// PURPOSE
//  Responder end of the instruction-fetch bus (req/gnt/addr -> rdata/rvalid/err) driven by the fetch stage.
//  Word-organised instruction RAM with a fixed read latency and a bounded number of outstanding requests.
//  Responses return strictly in order. A backdoor load port fills the RAM for simulation and boot.
// PARAMETERS
//  DEPTH_WORDS      1024  RAM size in 32-bit words (power of 2)
//  BASE_ADDR        0     byte address of word 0 (aligned to 4*DEPTH_WORDS)
//  LATENCY          1     cycles from grant to rvalid (1..4)
//  MAX_OUTSTANDING  2     max granted-but-unanswered requests (1..4)
// PORTS
//  clk             in   1   clock; all logic on posedge
//  rst             in   1   synchronous, active-high reset
//  instr_req_i     in   1   fetch request
//  instr_gnt_o     out  1   request accepted this cycle
//  instr_addr_i    in   32  byte address; bits [1:0] ignored
//  instr_rdata_o   out  32  instruction word
//  instr_err_o     out  1   access fault; valid only with rvalid
//  instr_rvalid_o  out  1   response valid, one cycle per grant
//  load_we_i       in   1   backdoor write enable
//  load_addr_i     in   32  backdoor byte address (word aligned)
//  load_wdata_i    in   32  backdoor write data
// BEHAVIOUR
//  - One clock, clk. Reset rst is synchronous and active-high.
//  - Reset: instr_rvalid_o=0, instr_err_o=0, instr_rdata_o=0, outstanding count=0, response pipe flushed.
//    RAM contents are preserved. Reset mid-operation silently drops in-flight responses.
//  - Grant (combinational): gnt = req & (outstanding < MAX_OUTSTANDING). The count includes responses
//    still in the pipe; a response leaving in the same cycle does not free a slot that cycle.
//  - Accept = req & gnt. Address is word = (addr - BASE_ADDR) >> 2.
//    Out of range (addr < BASE_ADDR or >= BASE_ADDR + 4*DEPTH_WORDS): err=1, rdata=0, RAM not read.
//  - Response pipe: LATENCY-stage shift register of {valid, err, data}.
//    An accept at cycle N gives rvalid=1 at cycle N+LATENCY. Back-to-back grants give back-to-back rvalids.
//  - Outstanding counter: +1 on accept, -1 on rvalid, unchanged when both happen. It never exceeds
//    MAX_OUTSTANDING and never underflows (assertion).
//  - The responder has no backpressure input; the requester must accept every rvalid.
//  - When rvalid=0, instr_rdata_o holds its last value and instr_err_o=0.
//  - Backdoor load: write lands in the RAM at the posedge. An out-of-range load is ignored.
//    A read and a load to the same word in the same cycle return the old data (read-first).
//  - Request dropped while gnt=0: nothing is queued; the requester re-presents it.
// CONFIGURATION
//  INSTR_MEM_STALL_INJECT_EN defined:
//  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on rst) advances every cycle.
//  - When lfsr[1:0]==2'b00, gnt is forced low that cycle.
//  - This exercises the fetch-stage stall path; latency and ordering rules are unchanged.
//  INSTR_MEM_STALL_INJECT_EN undefined: no LFSR is present; gnt follows the grant rule only.
// TESTING
//  1. Load word 0x10=0x00000013 via backdoor. Req addr=BASE+0x40, LATENCY=1 -> gnt same cycle;
//     next cycle rvalid=1, rdata=0x00000013, err=0.
//  2. Hold req for 6 cycles, MAX_OUTSTANDING=2, LATENCY=2 -> gnt pattern 1,1,0,1,1,0...;
//     each rvalid matches its grant 2 cycles later, in address order.
//  3. Req addr=BASE+4*DEPTH_WORDS -> rvalid with err=1, rdata=0. A following in-range req returns good data.
//  4. Grant two requests, assert rst for 1 cycle before the responses -> no rvalid after reset;
//     outstanding=0; next req granted immediately.
//  5. Same-cycle read and backdoor load of word 5 (old 0xAAAA_AAAA, new 0x5555_5555)
//     -> response 0xAAAA_AAAA; re-read -> 0x5555_5555.
//  6. With INSTR_MEM_STALL_INJECT_EN, 1000 random reqs -> some gnt=0 cycles; every grant answered
//     exactly once, in order, correct data.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: word RAM behind a req/gnt bus, in-order responses, backdoor load port.
// Latency: LATENCY cycles from grant to rvalid; back-to-back grants give back-to-back responses.
// Backpressure: gnt drops while MAX_OUTSTANDING responses are unanswered; no response-side stall.
// Optional: define INSTR_MEM_STALL_INJECT_EN to add LFSR-driven random grant stalls.
module instr_mem_responder #(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  output logic        instr_rvalid_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i
);

  localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;
  localparam int unsigned CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  // Instruction storage; contents survive reset
  logic [31:0] mem_q [DEPTH_WORDS];

  // Address decode: a single 33-bit offset compare covers both below-base
  // (offset wraps with bit 32 set) and beyond-end cases.
  logic [32:0]   req_off;
  logic [32:0]   load_off;
  logic          req_in_rng;
  logic          load_in_rng;
  logic [AW-1:0] req_word;
  logic [AW-1:0] load_word;

  assign req_off     = {1'b0, instr_addr_i} - {1'b0, BASE_ADDR};
  assign load_off    = {1'b0, load_addr_i} - {1'b0, BASE_ADDR};
  assign req_in_rng  = (req_off < SPAN);
  assign load_in_rng = (load_off < SPAN);
  assign req_word    = req_off[AW+1:2];
  assign load_word   = load_off[AW+1:2];

  // Grant-side state
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall;
  logic          accept;
  logic          rsp_vld;

`ifdef INSTR_MEM_STALL_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR state register, reseeded on reset
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // A response leaving this cycle still holds its slot until the next edge
  assign instr_gnt_o = instr_req_i & (cnt_q < MAX_C) & ~stall;
  assign accept      = instr_req_i & instr_gnt_o;

  // Response pipe: stage LATENCY-1 is the output register
  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [LATENCY-1:0] pipe_err_q, pipe_err_d;
  logic [31:0]        pipe_dat_q [LATENCY];
  logic [31:0]        pipe_dat_d [LATENCY];
  logic [LATENCY-1:0] stg_vld;
  logic [LATENCY-1:0] stg_err;
  logic [31:0]        stg_dat [LATENCY];

  assign rsp_vld = pipe_vld_q[LATENCY-1];

  // Shift the pipe; the output data only changes when a response arrives
  always_comb begin
    stg_vld    = '0;
    stg_err    = '0;
    pipe_vld_d = '0;
    pipe_err_d = '0;
    for (int i = 0; i < LATENCY; i++) begin
      stg_dat[i]    = '0;
      pipe_dat_d[i] = '0;
    end
    // Entry stage: RAM read happens only for accepted, in-range requests.
    // Reading here, before the edge, makes a same-cycle backdoor write read-first.
    stg_vld[0] = accept;
    stg_err[0] = accept & ~req_in_rng;
    stg_dat[0] = (accept && req_in_rng) ? mem_q[req_word] : 32'h0;
    for (int i = 1; i < LATENCY; i++) begin
      stg_vld[i] = pipe_vld_q[i-1];
      stg_err[i] = pipe_err_q[i-1];
      stg_dat[i] = pipe_dat_q[i-1];
    end
    for (int i = 0; i < LATENCY; i++) begin
      pipe_vld_d[i] = stg_vld[i];
      pipe_err_d[i] = stg_err[i];
      pipe_dat_d[i] = stg_dat[i];
    end
    if (!stg_vld[LATENCY-1]) begin
      pipe_dat_d[LATENCY-1] = pipe_dat_q[LATENCY-1];
    end
  end

  // Pipe registers; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q <= '0;
      pipe_err_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_dat_q[i] <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      pipe_err_q <= pipe_err_d;
      for (int i = 0; i < LATENCY; i++) pipe_dat_q[i] <= pipe_dat_d[i];
    end
  end

  assign instr_rvalid_o = rsp_vld;
  assign instr_err_o    = pipe_err_q[LATENCY-1];
  assign instr_rdata_o  = pipe_dat_q[LATENCY-1];

  // Outstanding count: up on accept, down on response, hold when both
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !rsp_vld)      cnt_d = cnt_q + CW'(1);
    else if (!accept && rsp_vld) cnt_d = cnt_q - CW'(1);
  end

  // Outstanding counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Backdoor load; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (load_we_i && load_in_rng) mem_q[load_word] <= load_wdata_i;
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt_q <= MAX_C);
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) rsp_vld |-> (cnt_q != '0));

endmodule
